// File: rtl/multicycle_controller.sv
// Multicycle control sequencer: Moore FSM driving datapath enables with memory wait states and a timeout trap.
// Define PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counter outputs.
module multicycle_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter int unsigned CNT_W          = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] Op,
   input  logic       Zero_Flag,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALU_op,
   output logic       RegDst,
   output logic       Demuxo,
   output logic       WeMD,
   output logic       ReMD,
   output logic       BRWe,
   output logic [3:0] state,
   output logic       trap
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EX   = 4'd10,
      ADDI_WB   = 4'd11,
      HALT      = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t      state_q, state_d;
   logic [31:0] wait_q, wait_d;
   logic        trap_q, trap_d;
   logic        waiting;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FETCH;
         wait_q  <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         trap_q  <= trap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      trap_d  = trap_q;
      waiting = 1'b0;
      case (state_q)
         FETCH: begin
            waiting = 1'b1;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            case (Op)
               OP_RTYPE:      state_d = EXEC_R;
               OP_LW, OP_SW:  state_d = MEM_ADDR;
               OP_BEQ:        state_d = BRANCH;
               OP_J:          state_d = JUMP;
               OP_ADDI:       state_d = ADDI_EX;
               default:       state_d = HALT;
            endcase
         end
         MEM_ADDR:  state_d = (Op == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ: begin
            waiting = 1'b1;
            if (mem_ready) state_d = MEM_WB;
         end
         MEM_WRITE: begin
            waiting = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXEC_R:    state_d = R_WB;
         ADDI_EX:   state_d = ADDI_WB;
         R_WB, MEM_WB, BRANCH, JUMP, ADDI_WB: state_d = FETCH;
         HALT:      state_d = HALT;
         default:   state_d = HALT;
      endcase
      // A completing access (mem_ready=1) always beats the timeout.
      if (waiting && !mem_ready) begin
         wait_d = wait_q + 32'd1;
         if ((TIMEOUT_CYCLES != 32'd0) && (wait_d >= TIMEOUT_CYCLES)) state_d = HALT;
      end
      if (state_d == HALT) trap_d = 1'b1;
   end

   always_comb begin
      PCWrite = 1'b0;
      PCSrc   = 2'b00;
      IRWrite = 1'b0;
      IorD    = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'b00;
      ALU_op  = 3'b000;
      RegDst  = 1'b0;
      Demuxo  = 1'b0;
      WeMD    = 1'b0;
      ReMD    = 1'b0;
      BRWe    = 1'b0;
      // Reset overrides the decode so nothing is written while RST is high.
      if (!RST) begin
         case (state_q)
            FETCH: begin
               ReMD    = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEM_READ: begin
               ReMD    = 1'b1;
               IorD    = 1'b1;
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEM_WB:   BRWe = 1'b1;
            MEM_WRITE: begin
               WeMD    = 1'b1;
               IorD    = 1'b1;
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            EXEC_R: begin
               ALUSrcA = 1'b1;
               ALU_op  = 3'b010;
            end
            R_WB: begin
               RegDst = 1'b1;
               Demuxo = 1'b1;
               BRWe   = 1'b1;
            end
            BRANCH: begin
               ALUSrcA = 1'b1;
               ALU_op  = 3'b001;
               PCSrc   = 2'b01;
               PCWrite = Zero_Flag;
            end
            JUMP: begin
               PCSrc   = 2'b10;
               PCWrite = 1'b1;
            end
            ADDI_EX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            ADDI_WB: begin
               Demuxo = 1'b1;
               BRWe   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;
   assign trap  = trap_q;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
   logic             instr_done;

   assign instr_done = (state_d == FETCH) &&
                       ((state_q == R_WB) || (state_q == MEM_WB) || (state_q == MEM_WRITE) ||
                        (state_q == BRANCH) || (state_q == JUMP) || (state_q == ADDI_WB));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if (state_q != HALT) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (instr_done)      instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: vector table for instruction flows plus reset, halt and timeout sequences.
module tb_multicycle_controller;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] Op = 6'd0;
   logic       Zero_Flag = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_ready_t = 1'b0;

   logic       PCWrite, IRWrite, IorD, ALUSrcA, RegDst, Demuxo, WeMD, ReMD, BRWe, trap;
   logic [1:0] PCSrc, ALUSrcB;
   logic [2:0] ALU_op;
   logic [3:0] state;

   logic       t_PCWrite, t_IRWrite, t_IorD, t_ALUSrcA, t_RegDst, t_Demuxo, t_WeMD, t_ReMD, t_BRWe, t_trap;
   logic [1:0] t_PCSrc, t_ALUSrcB;
   logic [2:0] t_ALU_op;
   logic [3:0] t_state;

`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt, t_cycle_cnt, t_instr_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   multicycle_controller dut (
      .CLK(CLK), .RST(RST), .Op(Op), .Zero_Flag(Zero_Flag), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALU_op(ALU_op), .RegDst(RegDst), .Demuxo(Demuxo), .WeMD(WeMD),
      .ReMD(ReMD), .BRWe(BRWe), .state(state), .trap(trap)
`ifdef PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   multicycle_controller #(.TIMEOUT_CYCLES(3)) dut_t (
      .CLK(CLK), .RST(RST), .Op(Op), .Zero_Flag(Zero_Flag), .mem_ready(mem_ready_t),
      .PCWrite(t_PCWrite), .PCSrc(t_PCSrc), .IRWrite(t_IRWrite), .IorD(t_IorD), .ALUSrcA(t_ALUSrcA),
      .ALUSrcB(t_ALUSrcB), .ALU_op(t_ALU_op), .RegDst(t_RegDst), .Demuxo(t_Demuxo), .WeMD(t_WeMD),
      .ReMD(t_ReMD), .BRWe(t_BRWe), .state(t_state), .trap(t_trap)
`ifdef PERF_CNT_EN
      , .cycle_cnt(t_cycle_cnt), .instr_cnt(t_instr_cnt)
`endif
   );

   // Output bundle: {PCWrite, PCSrc, IRWrite, IorD, ALUSrcA, ALUSrcB, ALU_op, RegDst, Demuxo, WeMD, ReMD, BRWe}
   logic [15:0] outs;
   assign outs = {PCWrite, PCSrc, IRWrite, IorD, ALUSrcA, ALUSrcB, ALU_op, RegDst, Demuxo, WeMD, ReMD, BRWe};

   localparam logic [15:0] O_F1   = 16'b1_00_1_0_0_01_000_0_0_0_1_0;
   localparam logic [15:0] O_F0   = 16'b0_00_0_0_0_01_000_0_0_0_1_0;
   localparam logic [15:0] O_DEC  = 16'b0_00_0_0_0_11_000_0_0_0_0_0;
   localparam logic [15:0] O_MA   = 16'b0_00_0_0_1_10_000_0_0_0_0_0;
   localparam logic [15:0] O_MR   = 16'b0_00_0_1_1_10_000_0_0_0_1_0;
   localparam logic [15:0] O_MWB  = 16'b0_00_0_0_0_00_000_0_0_0_0_1;
   localparam logic [15:0] O_MW   = 16'b0_00_0_1_1_10_000_0_0_1_0_0;
   localparam logic [15:0] O_EXR  = 16'b0_00_0_0_1_00_010_0_0_0_0_0;
   localparam logic [15:0] O_RWB  = 16'b0_00_0_0_0_00_000_1_1_0_0_1;
   localparam logic [15:0] O_BR1  = 16'b1_01_0_0_1_00_001_0_0_0_0_0;
   localparam logic [15:0] O_BR0  = 16'b0_01_0_0_1_00_001_0_0_0_0_0;
   localparam logic [15:0] O_JMP  = 16'b1_10_0_0_0_00_000_0_0_0_0_0;
   localparam logic [15:0] O_AEX  = 16'b0_00_0_0_1_10_000_0_0_0_0_0;
   localparam logic [15:0] O_AWB  = 16'b0_00_0_0_0_00_000_0_1_0_0_1;
   localparam logic [15:0] O_NONE = 16'b0;

   typedef struct {
      logic [5:0]  op;
      logic        zero;
      logic        ready;
      logic [3:0]  st;
      logic [15:0] o;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [5:0] op, input logic z, input logic r,
                      input logic [3:0] st, input logic [15:0] o);
      vec_t v;
      v.op = op; v.zero = z; v.ready = r; v.st = st; v.o = o;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      // R-type, lw, sw, beq taken/not taken, j, addi, lw with 2 waits, fetch with 2 waits
      add(6'h00, 0, 1, 0, O_F1);  add(6'h00, 0, 1, 1, O_DEC); add(6'h00, 0, 1, 6, O_EXR); add(6'h00, 0, 1, 7, O_RWB);
      add(6'h23, 0, 1, 0, O_F1);  add(6'h23, 0, 1, 1, O_DEC); add(6'h23, 0, 1, 2, O_MA);
      add(6'h23, 0, 1, 3, O_MR);  add(6'h23, 0, 1, 4, O_MWB);
      add(6'h2B, 0, 1, 0, O_F1);  add(6'h2B, 0, 1, 1, O_DEC); add(6'h2B, 0, 1, 2, O_MA); add(6'h2B, 0, 1, 5, O_MW);
      add(6'h04, 1, 1, 0, O_F1);  add(6'h04, 1, 1, 1, O_DEC); add(6'h04, 1, 1, 8, O_BR1);
      add(6'h04, 0, 1, 0, O_F1);  add(6'h04, 0, 1, 1, O_DEC); add(6'h04, 0, 1, 8, O_BR0);
      add(6'h02, 0, 1, 0, O_F1);  add(6'h02, 0, 1, 1, O_DEC); add(6'h02, 0, 1, 9, O_JMP);
      add(6'h08, 0, 1, 0, O_F1);  add(6'h08, 0, 1, 1, O_DEC); add(6'h08, 0, 1, 10, O_AEX); add(6'h08, 0, 1, 11, O_AWB);
      add(6'h23, 0, 1, 0, O_F1);  add(6'h23, 0, 1, 1, O_DEC); add(6'h23, 0, 1, 2, O_MA);
      add(6'h23, 0, 0, 3, O_MR);  add(6'h23, 0, 0, 3, O_MR);  add(6'h23, 0, 1, 3, O_MR); add(6'h23, 0, 1, 4, O_MWB);
      add(6'h00, 0, 0, 0, O_F0);  add(6'h00, 0, 0, 0, O_F0);  add(6'h00, 0, 1, 0, O_F1);
      add(6'h00, 0, 1, 1, O_DEC); add(6'h00, 0, 1, 6, O_EXR); add(6'h00, 0, 1, 7, O_RWB);

      do_reset();
      @(negedge CLK);
      chk("reset state", {28'd0, state}, 32'd0);
      chk("reset trap", {31'd0, trap}, 32'd0);
      @(posedge CLK); #1;
      do_reset();

      foreach (vecs[i]) begin
         Op = vecs[i].op; Zero_Flag = vecs[i].zero; mem_ready = vecs[i].ready;
         @(negedge CLK);
         $display("vec %0d: op=%h zero=%b ready=%b state=%0d outs=%b", i, Op, Zero_Flag, mem_ready, state, outs);
         chk($sformatf("vec%0d state", i), {28'd0, state}, {28'd0, vecs[i].st});
         chk($sformatf("vec%0d outs", i), {16'd0, outs}, {16'd0, vecs[i].o});
         chk($sformatf("vec%0d trap", i), {31'd0, trap}, 32'd0);
         @(posedge CLK); #1;
      end

      // Illegal opcode: HALT with sticky trap, held regardless of inputs.
      Op = 6'h3F; mem_ready = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      Op = 6'h00;
      for (int k = 0; k < 20; k++) begin
         mem_ready = k[0];
         @(negedge CLK);
         chk("halt state", {28'd0, state}, 32'd12);
         chk("halt trap", {31'd0, trap}, 32'd1);
         chk("halt outs", {16'd0, outs}, 32'd0);
         @(posedge CLK); #1;
      end
      $display("illegal opcode: state=%0d trap=%b", state, trap);
      do_reset();
      @(negedge CLK);
      chk("trap cleared by reset", {31'd0, trap}, 32'd0);
      @(posedge CLK); #1;

      // Reset asserted mid-MEM_READ.
      do_reset();
      Op = 6'h23; mem_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1 mem_ready = 1'b0;
      @(negedge CLK);
      chk("pre-reset MEM_READ", {28'd0, state}, 32'd3);
      #2 RST = 1'b1;
      #1;
      chk("async reset state", {28'd0, state}, 32'd0);
      chk("async reset outs", {16'd0, outs}, 32'd0);
      @(posedge CLK); #1;
      chk("held reset outs", {16'd0, outs}, 32'd0);
      RST = 1'b0; mem_ready = 1'b1;
      @(negedge CLK);
      chk("post-reset state", {28'd0, state}, 32'd0);
      chk("post-reset outs", {16'd0, outs}, {16'd0, O_F1});
      $display("mid-access reset: state=%0d ReMD=%b", state, ReMD);
      @(posedge CLK); #1;

      // Timeout boundary: 14 idle fetch cycles, then ready on the 15th wins.
      do_reset();
      Op = 6'h00; mem_ready = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge CLK);
         chk("wait14 state", {28'd0, state}, 32'd0);
         @(posedge CLK); #1;
      end
      mem_ready = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("ready wins state", {28'd0, state}, 32'd1);
      chk("ready wins trap", {31'd0, trap}, 32'd0);
      $display("timeout boundary: state=%0d trap=%b", state, trap);
      @(posedge CLK); #1;

      // Stuck memory: default instance traps after 15 waits, TIMEOUT_CYCLES=3 instance after 3.
      do_reset();
      mem_ready = 1'b0; mem_ready_t = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         chk($sformatf("stuck15 cyc%0d state", k), {28'd0, state}, (k <= 15) ? 32'd0 : 32'd12);
         chk($sformatf("stuck15 cyc%0d trap", k), {31'd0, trap}, (k <= 15) ? 32'd0 : 32'd1);
         if (k <= 5) begin
            chk($sformatf("stuck3 cyc%0d state", k), {28'd0, t_state}, (k <= 3) ? 32'd0 : 32'd12);
            chk($sformatf("stuck3 cyc%0d trap", k), {31'd0, t_trap}, (k <= 3) ? 32'd0 : 32'd1);
         end
         @(posedge CLK); #1;
      end
      $display("timeout: state=%0d trap=%b, short-timeout state=%0d trap=%b", state, trap, t_state, t_trap);

`ifdef PERF_CNT_EN
      do_reset();
      mem_ready = 1'b1;
      @(negedge CLK);
      chk("perf reset cycle_cnt", cycle_cnt, 32'd0);
      chk("perf reset instr_cnt", instr_cnt, 32'd0);
      @(posedge CLK); #1;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         Op = (k < 4) ? 6'h00 : (k < 8) ? 6'h2B : 6'h02;
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      chk("perf state", {28'd0, state}, 32'd0);
      chk("perf cycle_cnt", cycle_cnt, 32'd11);
      chk("perf instr_cnt", instr_cnt, 32'd3);
      $display("perf: cycle_cnt=%0d instr_cnt=%0d", cycle_cnt, instr_cnt);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style multicycle control FSM that sequences the shared ALU, register bank and data memory over several clock cycles per instruction.
- Replaces the purely combinational opcode decode with a cycle-level sequencer.
- Drives write/read enables, the ALU/memory writeback select (Demuxo) and the ALU_op field consumed by the ALU control decoder.
- Supports wait states from the memory and a timeout trap.

Parameters:
- TIMEOUT_CYCLES, 15: maximum consecutive cycles spent waiting on mem_ready before trapping. 0 disables the timeout.
- CNT_W, 32: width of the performance counters (used only with PERF_CNT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Op  in  6  opcode, instruction[31:26], sampled from the instruction register.
- Zero_Flag  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = branch target register, 10 = jump address.
- IRWrite  out  1  instruction register load.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = register RD1.
- ALUSrcB  out  2  ALU B operand: 00 = RD2, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- ALU_op  out  3  000 = add, 001 = sub, 010 = decode by funct.
- RegDst  out  1  register write address: 0 = rt, 1 = rd.
- Demuxo  out  1  register writeback source: 1 = ALU, 0 = memory.
- WeMD  out  1  data memory write enable.
- ReMD  out  1  data memory read enable.
- BRWe  out  1  register bank write enable.
- state  out  4  current state encoding, for debug.
- trap  out  1  sticky error flag.

Behaviour:
- Reset
  - While RST is high: state = FETCH (0), trap = 0, wait counter = 0.
  - All outputs are forced to 0 while RST is asserted, including FETCH's normally asserted enables.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 12.
- Outputs are decoded from state only. The two exceptions are the mem_ready gating of PCWrite/IRWrite in FETCH and the Zero_Flag gating of PCWrite in BRANCH. Any output not listed for a state is 0.
- FETCH
  - Outputs: ReMD=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALU_op=000 (branch target computed).
  - Transitions by Op:
    - 000000 -> EXEC_R
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDI_EX
    - any other -> HALT with trap set to 1
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=010 -> R_WB.
- R_WB: RegDst=1, Demuxo=1, BRWe=1 -> FETCH.
- MEM_ADDR
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALU_op=000.
  - Next state: lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: ReMD=1, IorD=1; hold the ALU address controls of MEM_ADDR; stay until mem_ready, then -> MEM_WB.
- MEM_WB: RegDst=0, Demuxo=0, BRWe=1 -> FETCH.
- MEM_WRITE: WeMD=1, IorD=1; hold the ALU address controls; stay until mem_ready, then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=001, PCSrc=01, PCWrite=Zero_Flag -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALU_op=000 -> ADDI_WB.
- ADDI_WB: RegDst=0, Demuxo=1, BRWe=1 -> FETCH.
- HALT: all enables 0; absorbing state; only RST exits.
- Latency in cycles, with zero wait states: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Wait counter and timeout
  - The wait counter increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - It clears on leaving the state.
  - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: next state = HALT, trap = 1.
  - If the timeout is reached on the same cycle that mem_ready=1, mem_ready wins and the access completes.
- trap is sticky and is cleared only by RST.
- Asserting RST mid-instruction aborts it immediately (asynchronously). No partial write is committed after the assert edge.

Optional Feature:
- PERF_CNT_EN
  - When defined, adds two outputs:
    - cycle_cnt [CNT_W-1:0]: increments every cycle not in HALT.
    - instr_cnt [CNT_W-1:0]: increments on every transition into FETCH from a completion state (R_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP, ADDI_WB).
  - Both counters reset to 0 and wrap modulo 2^CNT_W.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert RST mid-MEM_READ -> state=0 and all outputs 0 asynchronously; after RST drops, FETCH resumes with ReMD=1.
- R-type: Op=000000, mem_ready=1 -> state sequence 0,1,6,7,0; BRWe=1 and Demuxo=1 only in cycle 4; ALU_op=010 in EXEC_R.
- lw with 2 wait cycles: Op=100011, mem_ready low for 2 cycles in MEM_READ -> MEM_READ held 3 cycles, then MEM_WB with Demuxo=0 and BRWe=1; total 7 cycles.
- beq:
  - Op=000100, Zero_Flag=1 -> PCWrite=1 and PCSrc=01 in BRANCH.
  - Repeat with Zero_Flag=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- Illegal opcode and timeout:
  - Op=111111 -> HALT, trap=1, held for 20 cycles.
  - With TIMEOUT_CYCLES=3 and mem_ready stuck at 0 in FETCH -> HALT after 3 cycles.
- PERF_CNT_EN: run R-type, sw, j back-to-back, zero wait -> instr_cnt=3, cycle_cnt=11.
